// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between the I-cache and decode
//
// Purpose: issues sequential I-cache fetches, buffers the returned
// instructions with their PCs in a DEPTH-entry circular buffer and presents
// the oldest one to decode. A redirect flushes the buffer and any in-flight
// response and restarts fetching at the new target.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   stall                     freeze all state, suppress fetch
//   redirect, redirect_pc     flush and refetch at redirect_pc (bits[1:0] ignored)
//   icache_re, icache_addr    fetch request and byte address
//   instruction               memory data, valid the cycle after icache_re
//   inst_valid, inst, inst_pc, inst_next_pc   head entry towards decode
//   inst_ready                decode takes the head this cycle
//   count                     number of stored entries
//
// Configuration macro: FETCH_QUEUE_BYPASS_EN -- when defined, a response that
// arrives while the buffer is empty is shown to decode in the same cycle.

module fetch_queue #(
  parameter int                PC_W     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         icache_re,
  output logic [PC_W-1:0]              icache_addr,
  input  logic [31:0]                  instruction,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [PC_W-1:0]              inst_pc,
  output logic [PC_W-1:0]              inst_next_pc,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] flight_pc;
  logic            in_flight;
  logic [PC_W-1:0] last_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic [31:0]     buf_inst [DEPTH];
  logic [PC_W-1:0] buf_pc   [DEPTH];

  logic          run;
  logic          flush;
  logic [CW:0]   occupancy;
  logic          empty;
  logic          byp;
  logic          arrive;
  logic          enq;
  logic          head_deq;

  assign run   = ~stall;
  assign flush = run & redirect;
  assign empty = (cnt == '0);

  // Slots already promised: stored entries plus the response still in flight.
  assign occupancy = {1'b0, cnt} + {{CW{1'b0}}, in_flight};

  // Gated by rst so no request leaks out while reset is held.
  assign icache_re   = rst & run & (redirect | (occupancy < (CW+1)'(DEPTH)));
  assign icache_addr = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : fetch_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  // A response landing on an empty buffer is shown directly; a flush in the
  // same cycle discards it instead.
  assign byp = in_flight & empty & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign inst_valid   = ~empty | byp;
  assign inst         = ~empty ? buf_inst[rd_ptr] : (byp ? instruction : NOP);
  assign inst_pc      = ~empty ? buf_pc[rd_ptr]   : (byp ? flight_pc : last_pc);
  assign inst_next_pc = inst_pc + PC_W'(4);
  assign count        = cnt;

  // Redirect wins over both a dequeue and an arriving response.
  assign arrive   = run & ~redirect & in_flight;
  assign head_deq = run & ~redirect & ~empty & inst_ready;
  // A bypassed response taken by decode this cycle never occupies a slot.
  assign enq      = arrive & ~(byp & inst_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      flight_pc <= '0;
      in_flight <= 1'b0;
      last_pc   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
    end else if (run) begin
      in_flight <= icache_re;
      last_pc   <= inst_pc;
      if (icache_re) begin
        flight_pc <= icache_addr;
        fetch_pc  <= icache_addr + PC_W'(4);
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (enq)      wr_ptr <= wr_ptr + AW'(1);
        if (head_deq) rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt + CW'(enq) - CW'(head_deq);
      end
    end
  end

  // Entry storage needs no reset: count and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_inst[wr_ptr] <= instruction;
      buf_pc[wr_ptr]   <= flight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table-driven bench for fetch_queue
module tb_fetch_queue;

  localparam int PC_W  = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic            icache_re;
  logic [31:0]     icache_addr;
  logic [31:0]     instruction;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [31:0]     inst_pc;
  logic [31:0]     inst_next_pc;
  logic            inst_ready;
  logic [2:0]      count;

  fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .icache_re(icache_re), .icache_addr(icache_addr),
    .instruction(instruction), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_next_pc(inst_next_pc), .inst_ready(inst_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the fetch address as data and holds it until the next request.
  logic [31:0] mem_data = 32'hDEAD_BEEF;
  always @(posedge clk) if (icache_re) mem_data <= icache_addr;
  assign instruction = mem_data;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        re;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic add(input logic s, input logic r, input logic [31:0] rp, input logic rd,
                     input logic e_re, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input int e_cnt);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rp; v.ready = rd;
    v.re = e_re; v.addr = e_addr; v.valid = e_v; v.pc = e_pc; v.cnt = 3'(e_cnt);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_re, input logic [31:0] e_addr,
                               input logic e_v, input logic [31:0] e_pc, input logic [2:0] e_cnt);
    chk({tag, " icache_re"}, 32'(icache_re), 32'(e_re));
    if (e_re) chk({tag, " icache_addr"}, icache_addr, e_addr);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(e_v));
    chk({tag, " inst"}, inst, e_v ? e_pc : NOP);
    chk({tag, " inst_pc"}, inst_pc, e_pc);
    chk({tag, " inst_next_pc"}, inst_next_pc, e_pc + 32'd4);
    chk({tag, " count"}, 32'(count), 32'(e_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Hold inst_ready low: exactly four fetches fill the queue.
    add(0,0,0,0, 1,32'd0,  0,0,0);
    if (BYP) add(0,0,0,0, 1,32'd4, 1,0,0); else add(0,0,0,0, 1,32'd4, 0,0,0);
    add(0,0,0,0, 1,32'd8,  1,0,1);
    add(0,0,0,0, 1,32'd12, 1,0,2);
    add(0,0,0,0, 0,32'd16, 1,0,3);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 0,32'd16, 1,0,4);
    // Drain in order, then steady stream.
    add(0,0,0,1, 0,32'd16, 1,32'd0, 4);
    add(0,0,0,1, 1,32'd16, 1,32'd4, 3);
    add(0,0,0,1, 1,32'd20, 1,32'd8, 2);
    add(0,0,0,1, 1,32'd24, 1,32'd12,2);
    add(0,0,0,1, 1,32'd28, 1,32'd16,2);
    add(0,0,0,1, 1,32'd32, 1,32'd20,2);
    // Build count=3, then redirect to 0x103.
    add(0,0,0,0, 1,32'd36, 1,32'd24,2);
    add(0,1,32'h103,0, 1,32'h100, 1,32'd24,3);
    if (BYP) begin
      add(0,0,0,1, 1,32'h104, 1,32'h100,0);
      add(0,0,0,1, 1,32'h108, 1,32'h104,0);
      add(0,0,0,1, 1,32'h10c, 1,32'h108,0);
      for (int i = 0; i < 5; i++) add(1,(i==2),32'h200,1, 0,0, 1,32'h10c,0);
      add(0,0,0,1, 1,32'h110, 1,32'h10c,0);
      add(0,0,0,1, 1,32'h114, 1,32'h110,0);
      add(0,0,0,1, 1,32'h118, 1,32'h114,0);
      add(0,1,32'hFFFF_FFFE,1, 1,32'hFFFF_FFFC, 0,32'h114,0);
      add(0,0,0,1, 1,32'd0, 1,32'hFFFF_FFFC,0);
      add(0,0,0,1, 1,32'd4, 1,32'd0,0);
      add(0,0,0,1, 1,32'd8, 1,32'd4,0);
    end else begin
      add(0,0,0,1, 1,32'h104, 0,32'd24,0);
      add(0,0,0,1, 1,32'h108, 1,32'h100,1);
      add(0,0,0,1, 1,32'h10c, 1,32'h104,1);
      for (int i = 0; i < 5; i++) add(1,(i==2),32'h200,1, 0,0, 1,32'h108,1);
      add(0,0,0,1, 1,32'h110, 1,32'h108,1);
      add(0,0,0,1, 1,32'h114, 1,32'h10c,1);
      add(0,0,0,1, 1,32'h118, 1,32'h110,1);
      add(0,1,32'hFFFF_FFFE,1, 1,32'hFFFF_FFFC, 1,32'h114,1);
      add(0,0,0,1, 1,32'd0, 0,32'h114,0);
      add(0,0,0,1, 1,32'd4, 1,32'hFFFF_FFFC,1);
      add(0,0,0,1, 1,32'd8, 1,32'd0,1);
    end

    #12;
    check_outputs("reset", 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);

    @(negedge clk);
    rst = 1'b1;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      stall = vecs[i].stall; redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc; inst_ready = vecs[i].ready;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].re, vecs[i].addr,
                    vecs[i].valid, vecs[i].pc, vecs[i].cnt);
    end

    // Mid-stream reset with two stored entries.
    for (int k = 0; k < (BYP ? 2 : 1); k++) begin
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("count before reset", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    check_outputs("mid reset", 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1; inst_ready = 1'b1;
    #1;
    check_outputs("release", 1'b1, 32'd0, 1'b0, 32'd0, 3'd0);
    found = 1'b0;
    for (int k = 1; k <= 6 && !found; k++) begin
      @(negedge clk);
      #1;
      if (inst_valid) begin
        found = 1'b1;
        chk("release latency", 32'(k), BYP ? 32'd1 : 32'd2);
        chk("release inst_pc", inst_pc, 32'd0);
        chk("release inst", inst, 32'd0);
      end
    end
    if (!found) chk("release valid timeout", 32'(inst_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_W, default 32: PC and address width.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset; word aligned.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  global freeze, active high.
REQ-007 redirect  in  1  branch/jump taken; flush and refetch.
REQ-008 redirect_pc  in  PC_W  target of redirect.
REQ-009 icache_re  out  1  fetch request this cycle.
REQ-010 icache_addr  out  PC_W  fetch byte address.
REQ-011 instruction  in  32  memory read data, valid the cycle after icache_re; held by memory until the next icache_re.
REQ-012 inst_valid  out  1  head entry present.
REQ-013 inst  out  32  head instruction; 32'h00000013 (NOP) when inst_valid=0.
REQ-014 inst_pc  out  PC_W  PC of head instruction.
REQ-015 inst_next_pc  out  PC_W  inst_pc+4.
REQ-016 inst_ready  in  1  decode accepts head this cycle.
REQ-017 count  out  clog2(DEPTH+1)  stored entries.

Function
REQ-018 Internal state: fetch PC register, DEPTH-entry circular buffer of {instruction, pc}, read/write pointers, one in-flight flag with its PC.
REQ-019 icache_re=1 when stall=0 and (count + in-flight) < DEPTH, or when redirect=1 and stall=0.
REQ-020 icache_addr = redirect_pc with bits[1:0] forced to 0 when redirect=1, else fetch PC.
REQ-021 On issue the fetch PC becomes icache_addr+4, wrapping modulo 2^PC_W.
REQ-022 Cycle after an issue with stall=0: instruction and its PC are written at the write pointer; pointers wrap modulo DEPTH.
REQ-023 Dequeue occurs when inst_valid=1, inst_ready=1, stall=0; read pointer advances by one.
REQ-024 Enqueue and dequeue in the same cycle leave count unchanged; at full, a same-cycle enqueue is impossible by REQ-019.
REQ-025 redirect=1 with stall=0: all stored entries discarded, count=0, in-flight response from an earlier issue discarded, new fetch issued at redirect_pc the same cycle.
REQ-026 redirect has priority over a same-cycle dequeue and a same-cycle arriving response.
REQ-027 stall=1 freezes every register; icache_re=0; redirect and inst_ready are ignored; the source holds redirect until stall falls.
REQ-028 Steady state with inst_ready=1: one instruction delivered per cycle, PCs consecutive by 4.
REQ-029 Empty queue: inst_valid=0, inst=NOP, inst_pc holds the last head value.

Reset
REQ-030 rst low asynchronously clears: count=0, pointers=0, in-flight=0, inst_valid=0, inst=NOP, inst_pc=0, icache_re=0, fetch PC=RESET_PC.
REQ-031 First issue occurs on the first rising edge after rst deasserts with stall=0, at RESET_PC.
REQ-032 Reset mid-operation discards all entries and in-flight responses; no stale instruction appears after release.

Configuration
REQ-033 Macro FETCH_QUEUE_BYPASS_EN.
REQ-034 Defined: a response arriving while count=0 drives inst/inst_pc and inst_valid=1 combinationally the same cycle; if dequeued that cycle it is not stored. Redirect-to-valid latency 1 cycle.
REQ-035 Undefined: every response is stored first; visible the following cycle. Redirect-to-valid latency 2 cycles.

Verification
REQ-036 Release reset, inst_ready=1, memory returns addr as data -> icache_addr 0,4,8,...; inst_pc 0,4,8 consecutive, inst equals inst_pc, no gaps after first valid.
REQ-037 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues, count=4, icache_re=0; raise inst_ready -> PCs 0,4,8,12,16 delivered in order.
REQ-038 count=3, redirect=1, redirect_pc=0x103 -> icache_addr=0x100 same cycle, count=0, next valid inst_pc=0x100 at latency 1 (bypass) / 2 (no bypass); old entries never emitted.
REQ-039 stall=1 for 5 cycles mid-stream with redirect pulsed -> no state change, icache_re=0, redirect ignored; stream resumes at the pre-stall PC.
REQ-040 Assert rst low mid-stream with count=2 -> outputs at reset values immediately; after release first inst_pc=RESET_PC.
REQ-041 Fetch PC at 2^PC_W-4 -> next icache_addr=0.
